// File: rtl/dec_scan_if.sv
// Bus bundle for dec_scan: enable/mode/address in, registered one-hot strobe and scan status out.
interface dec_scan_if #(
  parameter int unsigned N = 3
);
  logic              E;
  logic              mode;
  logic [N-1:0]      A;
  logic [(1<<N)-1:0] Y;
  logic [N-1:0]      idx;
  logic              wrap;

  modport master (output E, mode, A, input Y, idx, wrap);
  modport slave  (input E, mode, A, output Y, idx, wrap);
endinterface

// File: rtl/dec_scan.sv
// Registered N-to-2^N one-hot decoder with an auto-scan mode that strobes every line
// for DWELL enabled clocks in turn.
module dec_scan #(
  parameter int unsigned N     = 3,
  parameter int unsigned DWELL = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  dec_scan_if.slave bus
);
  localparam int unsigned W    = 1 << N;
  localparam int unsigned CntW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DWELL - 1);

  typedef enum logic {StAddr, StScan} state_e;

  state_e          r_state, w_state;
  logic [N-1:0]    r_idx, w_idx;
  logic [CntW-1:0] r_cnt, w_cnt;
  logic [W-1:0]    r_y, w_y;
  logic            r_wrap, w_wrap;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StAddr;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_y     <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_idx   <= w_idx;
      r_cnt   <= w_cnt;
      r_y     <= w_y;
      r_wrap  <= w_wrap;
    end
  end

  always_comb begin
    w_state = bus.mode ? StScan : StAddr;
    w_idx   = r_idx;
    w_cnt   = r_cnt;
    w_wrap  = 1'b0;
    if (!bus.mode) begin
      w_idx = bus.A;
      w_cnt = '0;
    end else if (r_state == StAddr) begin
      // Entry edge is the first dwell cycle of the current index.
      w_cnt = '0;
    end else if (bus.E) begin
      if (r_cnt == CntMax) begin
        w_cnt  = '0;
        w_idx  = r_idx + 1'b1;
        w_wrap = (r_idx == {N{1'b1}});
      end else begin
        w_cnt = r_cnt + 1'b1;
      end
    end
    w_y = bus.E ? (W'(1) << w_idx) : '0;
  end

  assign bus.Y    = r_y;
  assign bus.idx  = r_idx;
  assign bus.wrap = r_wrap;
endmodule

// File: tb/tb_dec_scan.sv
// Scoreboard bench for dec_scan: two instances (DWELL=4 and DWELL=1) share stimulus and are
// checked against a countdown-based reference model.
module tb_dec_scan;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dec_scan_if #(.N(3)) if4 ();
  dec_scan_if #(.N(3)) if1 ();

  dec_scan #(.N(3), .DWELL(4)) u_d4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  dec_scan #(.N(3), .DWELL(1)) u_d1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  typedef struct packed {
    logic [7:0] y;
    logic [2:0] idx;
    logic       wrap;
  } exp_t;

  typedef struct {
    int idx;
    int rem;   // enabled cycles still owed at idx after the current one
    bit scan;
  } ms_t;

  exp_t q4[$];
  exp_t q1[$];
  ms_t  m4, m1;
  int   checks = 0;
  int   passed = 0;
  int   ncyc   = 0;

  function automatic ms_t mstep(ms_t s, bit rst, bit e, bit mode, int a, int dwell,
                                output exp_t x);
    x.wrap = 1'b0;
    if (!rst) begin
      s.idx = 0; s.rem = 0; s.scan = 0;
      x.y = 8'h00; x.idx = 3'd0;
      return s;
    end
    if (!mode) begin
      s.idx = a;
      s.rem = 0;
    end else if (!s.scan) begin
      s.rem = dwell - 1;
    end else if (e) begin
      if (s.rem == 0) begin
        x.wrap = (s.idx == 7);
        s.idx  = (s.idx + 1) % 8;
        s.rem  = dwell - 1;
      end else begin
        s.rem--;
      end
    end
    s.scan = mode;
    x.idx  = s.idx[2:0];
    x.y    = e ? 8'(1 << s.idx) : 8'h00;
    return s;
  endfunction

  task automatic cyc(input bit rst, input bit e, input bit mode, input int a);
    exp_t x;
    @(negedge clk);
    rst_n = rst;
    if4.E = e; if4.mode = mode; if4.A = 3'(a);
    if1.E = e; if1.mode = mode; if1.A = 3'(a);
    m4 = mstep(m4, rst, e, mode, a, 4, x);
    q4.push_back(x);
    m1 = mstep(m1, rst, e, mode, a, 1, x);
    q1.push_back(x);
  endtask

  task automatic compare(input string name, input exp_t exp, input logic [7:0] y,
                         input logic [2:0] idx, input logic wrap);
    checks++;
    if (y === exp.y && idx === exp.idx && wrap === exp.wrap) passed++;
    else
      $display("FAIL %s cyc %0d: got Y=%h idx=%0d wrap=%b, expected Y=%h idx=%0d wrap=%b",
               name, ncyc, y, idx, wrap, exp.y, exp.idx, exp.wrap);
  endtask

  // Monitor: outputs are registered, so every edge presents one response per instance.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q4.size() > 0) compare("dwell4", q4.pop_front(), if4.Y, if4.idx, if4.wrap);
      if (q1.size() > 0) compare("dwell1", q1.pop_front(), if1.Y, if1.idx, if1.wrap);
      ncyc++;
    end
  end

  initial begin
    int mode_r;
    rst_n = 1'b0;
    if4.E = 1'b0; if4.mode = 1'b0; if4.A = '0;
    if1.E = 1'b0; if1.mode = 1'b0; if1.A = '0;
    m4 = '{idx: 0, rem: 0, scan: 0};
    m1 = m4;

    // Reset held with scan requested, then release into scan entry from 0
    cyc(0, 1, 1, 5); cyc(0, 1, 1, 5);
    cyc(1, 1, 1, 5);
    // Address sweep, then disabled decode
    for (int a = 0; a < 8; a++) cyc(1, 1, 0, a);
    cyc(1, 0, 0, 6);
    // Scan from 6 through the wrap
    cyc(1, 1, 0, 6);
    for (int i = 0; i < 12; i++) cyc(1, 1, 1, 0);
    // Pause at idx=2, cnt=1 and resume
    cyc(1, 1, 0, 2);
    cyc(1, 1, 1, 0); cyc(1, 1, 1, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0);
    for (int i = 0; i < 4; i++) cyc(1, 1, 1, 0);
    // Exit mid-scan
    cyc(1, 1, 0, 3);
    for (int i = 0; i < 3; i++) cyc(1, 1, 1, 0);
    cyc(1, 1, 0, 1);
    // Nine-edge scan from 0 (wrap on the DWELL=1 instance)
    cyc(1, 1, 0, 0);
    for (int i = 0; i < 9; i++) cyc(1, 1, 1, 0);
    // Entry with E low
    cyc(1, 1, 0, 4); cyc(1, 0, 1, 0); cyc(1, 1, 1, 0);
    // Reset mid-scan
    cyc(1, 1, 0, 5);
    cyc(1, 1, 1, 0); cyc(1, 1, 1, 0);
    cyc(0, 1, 1, 0);
    for (int i = 0; i < 6; i++) cyc(1, 1, 1, 0);

    // Random phase
    mode_r = 1;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 19) == 0) mode_r = ~mode_r & 1;
      cyc(($urandom_range(0, 99) != 0), ($urandom_range(0, 99) < 85), mode_r[0],
          $urandom_range(0, 7));
    end

    // Drain: bounded wait for the monitor to consume every expectation
    for (int i = 0; i < 10 && (q4.size() > 0 || q1.size() > 0); i++) @(posedge clk);
    #2;
    checks++;
    if (q4.size() == 0 && q1.size() == 0) passed++;
    else $display("FAIL drain: got %0d/%0d pending, expected 0/0", q4.size(), q1.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
